// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor: opcodes, FSM states and
// the opcode decode used to form the effective B operand and carry-in.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic inv_b;
        logic cin;
    } op_ctl_t;

    // Subtraction is A + ~B + 1; SBC takes Ci as "no borrow".
    function automatic op_ctl_t op_decode(op_e op, logic ci);
        op_ctl_t ctl;
        ctl.inv_b = (op == OP_SUB) || (op == OP_SBC);
        unique case (op)
            OP_ADD:  ctl.cin = 1'b0;
            OP_SUB:  ctl.cin = 1'b1;
            default: ctl.cin = ci;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operation request / result bundle between the control unit and addsub_serial.
interface addsub_serial_if #(
    parameter int unsigned WIDTH = 9
);
    import addsub_pkg::*;

    logic             Start;
    logic             Ready;
    op_e              Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             V;
    logic             Z;
    logic             N;
    logic             Done;

    modport master (
        output Start, Op, A, B, Ci,
        input  Ready, S, Co, V, Z, N, Done
    );

    modport slave (
        input  Start, Op, A, B, Ci,
        output Ready, S, Co, V, Z, N, Done
    );

endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice built from 1-bit full-adder cells;
// also exposes the carry into its MSB for overflow detection.
module addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_digit #(
    parameter int unsigned DIGIT = 3
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        addsub_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/sub: DIGIT bits per clock through a registered carry, with
// Start/Ready/Done handshake and registered result flags.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DIGIT = 3
) (
    input logic           Clock,
    input logic           Reset,
    addsub_serial_if.slave bus
);

    localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT == 0 || (WIDTH % ((DIGIT == 0) ? 1 : DIGIT)) != 0) begin : g_bad_param
        $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_e state_q, state_d;
    logic   load, last;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout, dcmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    op_ctl_t                ctl;

    assign ctl      = op_decode(bus.Op, bus.Ci);
    assign last     = (cnt_q == CW'(NDIG - 1));
    // New digit enters at the top, so after NDIG shifts the result is aligned.
    assign res_cat  = {dsum, res_q};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        bus.Ready = 1'b1;
        bus.Done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.Ready = 1'b0;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                bus.Done = 1'b1;
                if (bus.Start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bus.S   <= '0;
            bus.Co  <= 1'b0;
            bus.V   <= 1'b0;
            bus.Z   <= 1'b0;
            bus.N   <= 1'b0;
        end else if (load) begin
            a_q     <= bus.A;
            b_q     <= ctl.inv_b ? ~bus.B : bus.B;
            carry_q <= ctl.cin;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= dcout;
            res_q   <= res_next;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                bus.S  <= res_next;
                bus.Co <= dcout;
                bus.V  <= dcmsb ^ dcout;
                bus.Z  <= (res_next == '0);
                bus.N  <= res_next[WIDTH-1];
            end
        end
    end

endmodule
